// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a 512x32 single-port memory: IDLE -> ACCESS -> ACK per transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority (port 1 wins).
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic          p0_ack_q, p1_ack_q, busy_q, mem_write_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, p0_rdata_q, p1_rdata_q;
    logic          pick1_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, hand the grant to whichever port was not served last.
    assign pick1_d = p1_req && (!p0_req || !last_grant_q);
`else
    assign pick1_d = p1_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        last_grant_q <= pick1_d;
                        mem_addr_q   <= pick1_d ? p1_addr : p0_addr;
                        if (pick1_d) begin
                            mem_wdata_q <= p1_wdata;
                        end
                        mem_write_q  <= pick1_d && p1_we;
                        busy_q       <= 1'b1;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The memory completes any write at this edge; read data is combinational.
                    mem_write_q <= 1'b0;
                    if (last_grant_q) begin
                        p1_ack_q <= 1'b1;
                        if (!mem_write_q) begin
                            p1_rdata_q <= mem_rdata;
                        end
                    end else begin
                        p0_ack_q   <= 1'b1;
                        p0_rdata_q <= mem_rdata;
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_ack    = p1_ack_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 512x32 memory model.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p0_req = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0;
    logic          p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:511];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int wr_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input logic port, input logic [DW-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every ack pops the scoreboard and checks port order and returned data.
    always @(negedge clk) begin
        exp_t e;
        if (mem_write) wr_cycles++;
        if (p0_ack && p1_ack) begin
            n_vec++;
            n_err++;
            $display("FAIL dual_ack: got both acks high, expected one");
        end else if (p0_ack || p1_ack) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_ack: got ack on port %0d, expected none", p1_ack);
            end else begin
                e = sb.pop_front();
                check("ack_port", {31'b0, p1_ack}, {31'b0, e.port});
                check("ack_data", p1_ack ? p1_rdata : p0_rdata, e.data);
            end
        end
    end

    task automatic txn(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp, input logic drop_early);
        int lat;
        @(negedge clk);
        expect_ack(port, exp);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end else begin
            p0_req = 1'b1; p0_addr = addr;
        end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (drop_early && c == 1) begin
                p0_req = 1'b0; p1_req = 1'b0;
            end
            if (port ? p1_ack : p0_ack) begin
                lat = c;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check(port ? "p1_latency" : "p0_latency", 32'(lat), 32'd2);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p0_ack"}, {31'b0, p0_ack}, 32'd0);
        check({tag, "_p1_ack"}, {31'b0, p1_ack}, 32'd0);
        check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
        check({tag, "_mem_addr"}, {23'b0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_p0_rdata"}, p0_rdata, 32'd0);
        check({tag, "_p1_rdata"}, p1_rdata, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, t0, t1, nacks;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0100_0000 + i;
        mem[9'h005] = 32'h0000_A5A5;
        mem[9'h003] = 32'h3333_3333;
        mem[9'h004] = 32'h4444_4444;
        mem[9'h1FF] = 32'h1111_1111;
        mem[9'h010] = 32'h0000_0000;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Port-0 read
        w0 = wr_cycles;
        txn(1'b0, 1'b0, 9'h005, 32'h0, 32'h0000_A5A5, 1'b0);
        @(negedge clk);
        check("p0_no_write", 32'(wr_cycles - w0), 32'd0);
        check("p0_rdata_held", p0_rdata, 32'h0000_A5A5);
        check("busy_idle_after_p0", {31'b0, busy}, 32'd0);

        // Port-1 write, then read back
        w0 = wr_cycles;
        txn(1'b1, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("p1_write_cycles", 32'(wr_cycles - w0), 32'd1);
        check("mem_1ff", mem[9'h1FF], 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 9'h1FF, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Tie after reset: port 1 first, port 0 three cycles later
        pulse_reset();
        @(negedge clk);
        expect_ack(1'b1, 32'h4444_4444);
        expect_ack(1'b0, 32'h3333_3333);
        p0_req = 1'b1; p0_addr = 9'h003;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h004;
        t0 = -1; t1 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (p1_ack) begin t1 = c; p1_req = 1'b0; end
            if (p0_ack) begin t0 = c; p0_req = 1'b0; end
            if (t0 >= 0 && t1 >= 0) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("tie_p1_cycle", 32'(t1), 32'd2);
        check("tie_p0_cycle", 32'(t0), 32'd5);

        // Both requests held for four transactions
        pulse_reset();
        @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expect_ack(1'b1, 32'h4444_4444);
        expect_ack(1'b0, 32'h3333_3333);
        expect_ack(1'b1, 32'h4444_4444);
        expect_ack(1'b0, 32'h3333_3333);
`else
        for (int k = 0; k < 4; k++) expect_ack(1'b1, 32'h4444_4444);
`endif
        p0_req = 1'b1; p0_addr = 9'h003;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h004;
        nacks = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) nacks++;
            if (nacks == 4) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("held_ack_count", 32'(nacks), 32'd4);
        repeat (2) @(negedge clk);
        check("busy_after_held", {31'b0, busy}, 32'd0);

        // Reset during ACCESS of a port-1 write: write lands, no ack
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h010; p1_wdata = 32'h1234_5678;
        @(negedge clk);
        check("rst_access_busy", {31'b0, busy}, 32'd1);
        check("rst_access_write", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        p1_req = 1'b0; p1_we = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("mem_010", mem[9'h010], 32'h1234_5678);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Request dropped during ACCESS still completes exactly once
        txn(1'b0, 1'b0, 9'h005, 32'h0, 32'h0000_A5A5, 1'b1);
        repeat (4) @(negedge clk);
        check("busy_after_drop", {31'b0, busy}, 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
